// File: rtl/load_store_unit.sv
// Load/store unit: turns RV32I byte/half/word accesses into word-wide
// memory cycles. Sub-word stores use a read-modify-write of the word.
module load_store_unit #(
  parameter int MEM_BYTES = 1024
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [2:0]  req_funct3_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  output logic        resp_valid_o,
  output logic [31:0] resp_rdata_o,
  output logic        resp_err_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic [31:0] mem_rdata_i
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_STORE, S_RMW_RD, S_RMW_WR, S_DONE
  } state_e;

  state_e      state_q, state_d;
  logic        we_q;
  logic [2:0]  funct3_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] word_q, word_d;
  logic [31:0] resp_rdata_q, resp_rdata_d;
  logic        resp_err_q, resp_err_d;

  logic        accept;
  logic        req_err;
  logic        misaligned;
  logic        illegal_f3;
  logic        out_of_range;
  logic [31:0] load_val;
  logic [31:0] merged;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  assign accept = req_valid_i & req_ready_o;

  // Classify the incoming request; errors are decided once, at acceptance.
  always_comb begin
    misaligned = 1'b0;
    case (req_funct3_i)
      3'd1, 3'd5: misaligned = req_addr_i[0];
      3'd2:       misaligned = (req_addr_i[1:0] != 2'b00);
      default:    misaligned = 1'b0;
    endcase
    if (req_we_i) illegal_f3 = (req_funct3_i > 3'd2);
    else          illegal_f3 = (req_funct3_i == 3'd3) || (req_funct3_i > 3'd5);
    out_of_range = ({req_addr_i[31:2], 2'b00} > 32'(MEM_BYTES - 4));
    req_err = misaligned | illegal_f3 | out_of_range;
  end

  // Select the addressed lane from the read word and extend it.
  always_comb begin
    lane_b = mem_rdata_i[8*addr_q[1:0] +: 8];
    lane_h = addr_q[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];
    case (funct3_q)
      3'd0:    load_val = {{24{lane_b[7]}}, lane_b};
      3'd1:    load_val = {{16{lane_h[15]}}, lane_h};
      3'd2:    load_val = mem_rdata_i;
      3'd4:    load_val = {24'd0, lane_b};
      3'd5:    load_val = {16'd0, lane_h};
      default: load_val = 32'd0;
    endcase
  end

  // Replace the stored lane(s) inside the word captured during RMW_RD.
  always_comb begin
    merged = word_q;
    if (funct3_q[0]) begin
      if (addr_q[1]) merged[31:16] = wdata_q[15:0];
      else           merged[15:0]  = wdata_q[15:0];
    end else begin
      merged[8*addr_q[1:0] +: 8] = wdata_q[7:0];
    end
  end

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (req_err)                   state_d = S_DONE;
          else if (!req_we_i)            state_d = S_LOAD;
          else if (req_funct3_i == 3'd2) state_d = S_STORE;
          else                           state_d = S_RMW_RD;
        end
      end
      S_LOAD:   state_d = S_DONE;
      S_STORE:  state_d = S_DONE;
      S_RMW_RD: state_d = S_RMW_WR;
      S_RMW_WR: state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Outputs decoded from the current state.
  always_comb begin
    req_ready_o  = (state_q == S_IDLE) & ~rst_i;
    resp_valid_o = (state_q == S_DONE);
    mem_we_o     = (state_q == S_STORE) || (state_q == S_RMW_WR);
    mem_wdata_o  = 32'd0;
    if (state_q == S_STORE)  mem_wdata_o = wdata_q;
    if (state_q == S_RMW_WR) mem_wdata_o = merged;
  end

  // Response and captured-word updates; they hold between accesses.
  always_comb begin
    word_d       = word_q;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;
    case (state_q)
      S_IDLE: begin
        if (accept && req_err) begin
          resp_rdata_d = 32'd0;
          resp_err_d   = 1'b1;
        end
      end
      S_LOAD: begin
        resp_rdata_d = load_val;
        resp_err_d   = 1'b0;
      end
      S_RMW_RD: word_d = mem_rdata_i;
      S_STORE, S_RMW_WR: begin
        resp_rdata_d = 32'd0;
        resp_err_d   = 1'b0;
      end
      default: ;
    endcase
  end

  // Request latch and datapath registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      we_q         <= 1'b0;
      funct3_q     <= 3'd0;
      addr_q       <= 32'd0;
      wdata_q      <= 32'd0;
      word_q       <= 32'd0;
      resp_rdata_q <= 32'd0;
      resp_err_q   <= 1'b0;
    end else begin
      if (accept) begin
        we_q     <= req_we_i;
        funct3_q <= req_funct3_i;
        addr_q   <= req_addr_i;
        wdata_q  <= req_wdata_i;
      end
      word_q       <= word_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
    end
  end

  assign mem_addr_o   = {addr_q[31:2], 2'b00};
  assign resp_rdata_o = resp_rdata_q;
  assign resp_err_o   = resp_err_q;

  // we_q is kept for visibility of the latched request; only the state uses it.
  logic unused_ok;
  assign unused_ok = we_q;

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter MEM_BYTES, default 1024: size of the byte-addressed data memory this unit drives.
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 req_valid  input  1  core presents an access request.
REQ-005 req_ready  output  1  unit accepts a request this cycle.
REQ-006 req_we  input  1  1 = store, 0 = load.
REQ-007 req_funct3  input  3  RV32I width code: 0 LB/SB, 1 LH/SH, 2 LW/SW, 4 LBU, 5 LHU.
REQ-008 req_addr  input  32  byte address.
REQ-009 req_wdata  input  32  store data, right-aligned.
REQ-010 resp_valid  output  1  one-cycle pulse, access complete.
REQ-011 resp_rdata  output  32  load result, extended per funct3; 0 for stores and errors.
REQ-012 resp_err  output  1  valid with resp_valid; misaligned, illegal funct3 or out-of-range.
REQ-013 mem_we  output  1  word write strobe to data memory.
REQ-014 mem_addr  output  32  word-aligned byte address to data memory.
REQ-015 mem_wdata  output  32  little-endian word to write.
REQ-016 mem_rdata  input  32  combinational little-endian read word from mem_addr.

Function
REQ-017 States: IDLE, LOAD, STORE, RMW_RD, RMW_WR, DONE; req_ready = 1 only in IDLE.
REQ-018 Acceptance = req_valid & req_ready; the unit latches we, funct3, addr, wdata; mem_addr = {addr[31:2],2'b00} thereafter.
REQ-019 Errors, checked at acceptance: LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]!=0; funct3 3,6,7 (load) or 3-7 (store); word address > MEM_BYTES-4.
REQ-020 On error: IDLE->DONE, no memory cycle, mem_we never asserted; response carries resp_err=1, resp_rdata=0.
REQ-021 Loads: IDLE->LOAD->DONE; in LOAD mem_we=0; mem_rdata captured at end of LOAD; resp_valid 2 cycles after acceptance.
REQ-022 Load extraction: byte lane = addr[1:0], half lane = addr[1]; LB/LH sign-extend, LBU/LHU zero-extend, LW unmodified.
REQ-023 SW: IDLE->STORE->DONE; mem_we=1 for exactly the STORE cycle with mem_wdata=wdata.
REQ-024 SB/SH: IDLE->RMW_RD->RMW_WR->DONE; RMW_RD reads and captures the word (mem_we=0); RMW_WR writes captured word with selected lane(s) replaced by wdata[7:0]/wdata[15:0], other bytes unchanged; resp_valid 3 cycles after acceptance.
REQ-025 mem_we = 1 only in STORE and RMW_WR; mem_wdata = 0 in all other states.
REQ-026 DONE lasts one cycle, asserts resp_valid, then returns to IDLE; the next request may be accepted the following cycle.
REQ-027 req_valid while not in IDLE is ignored; the core must hold the request until accepted.
REQ-028 resp_rdata and resp_err hold their last values between pulses; only resp_valid qualifies them.

Reset
REQ-029 rst=1 immediately forces IDLE; resp_valid=0, resp_err=0, resp_rdata=0, mem_we=0, mem_addr=0, mem_wdata=0, req_ready=1 while rst is low.
REQ-030 Reset during any in-flight access abandons it: no response, no further memory write; a write already clocked into memory is not undone.
REQ-031 req_ready=0 while rst=1; first acceptance is possible in the first cycle after rst deasserts.

Verification
REQ-032 Memory word @0x10 = 0x8899AABB; LB addr 0x11 -> resp_rdata 0xFFFFFFAA; LBU 0x11 -> 0x000000AA; LH 0x12 -> 0xFFFF8899; LW 0x10 -> 0x8899AABB; each resp_valid 2 cycles after acceptance.
REQ-033 SB addr 0x12, wdata 0x12345677 on word 0x8899AABB -> mem_we one cycle in RMW_WR, word becomes 0x8877AABB, resp_valid 3 cycles after acceptance, resp_err=0.
REQ-034 SW addr 0x20, wdata 0xDEADBEEF -> single mem_we cycle, mem_addr 0x20, bytes 0x20..0x23 = EF BE AD DE.
REQ-035 LW addr 0x13, SH addr 0x21, LB funct3=3, LW addr MEM_BYTES-2 -> each resp_err=1, resp_rdata=0, mem_we never asserted, resp_valid 1 cycle after acceptance.
REQ-036 Assert rst during RMW_RD of an SB -> outputs zero immediately, no mem_we, no resp_valid; memory word unchanged; next LW returns the original value.
REQ-037 Back-to-back: req_valid held high with LW then SW -> second accepted the cycle after the first resp_valid; req_ready low throughout the busy states.
